// File: rtl/afe_sync_sequencer.sv
// afe_sync_sequencer: drives the AFE sync pin. After enable it issues one
// delayed initial sync, then serves level resync requests round-robin.
// Each pulse is pre-delayed by `delay` cycles, lasts max(pulse_len,1) cycles
// and is followed by HOLDOFF low cycles before the next grant.
// Optional feature macro: AFE_SYNC_AUTO_RESYNC_EN (periodic automatic resync
// after RESYNC_PERIOD idle cycles in READY).
module afe_sync_sequencer #(
  parameter int NUM_REQ       = 4,
  parameter int CNT_W         = 20,
  parameter int PLEN_W        = 4,
  parameter int HOLDOFF       = 16,
  parameter int RESYNC_PERIOD = 1000000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [CNT_W-1:0]   delay,
  input  logic [PLEN_W-1:0]  pulse_len,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               sync,
  output logic               busy,
  output logic               locked
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int HO_W  = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
`ifdef AFE_SYNC_AUTO_RESYNC_EN
  localparam int TMR_W = (RESYNC_PERIOD < 2) ? 1 : $clog2(RESYNC_PERIOD);
`else
  localparam int unused_resync_period = RESYNC_PERIOD;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PULSE,
    S_GAP,
    S_READY
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PLEN_W-1:0]  pcnt;
  logic [HO_W-1:0]    gcnt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [PTR_W-1:0]   scan_idx;
  logic               pick_vld;
  logic               en_q;
`ifdef AFE_SYNC_AUTO_RESYNC_EN
  logic [TMR_W-1:0]   tmr;
`endif

  // Round-robin scan: walk from the highest offset down so the set bit
  // nearest to (at or after) the pointer is the one left standing.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  assign next_ptr = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

  // Enable history: the initial sequence starts only once enable has been
  // seen high on a previous edge, giving the delay+2 edge initial latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q <= 1'b0;
    end else begin
      en_q <= enable;
    end
  end

  // Sequencer FSM with registered sync/grant/done/busy/locked outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      pcnt   <= '0;
      gcnt   <= '0;
      ptr    <= '0;
      sync   <= 1'b0;
      grant  <= '0;
      done   <= '0;
      busy   <= 1'b0;
      locked <= 1'b0;
`ifdef AFE_SYNC_AUTO_RESYNC_EN
      tmr    <= '0;
`endif
    end else begin
      done <= '0;
      if (!enable) begin
        // Abort: drop everything except the arbitration pointer.
        state  <= S_IDLE;
        cnt    <= '0;
        pcnt   <= '0;
        gcnt   <= '0;
        sync   <= 1'b0;
        grant  <= '0;
        busy   <= 1'b0;
        locked <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (en_q) begin
              cnt   <= delay;
              busy  <= 1'b1;
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (cnt == '0) begin
              pcnt  <= (pulse_len == '0) ? PLEN_W'(1) : pulse_len;
              sync  <= 1'b1;
              state <= S_PULSE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_PULSE: begin
            if (pcnt <= PLEN_W'(1)) begin
              sync   <= 1'b0;
              done   <= grant;
              locked <= 1'b1;
              if (HOLDOFF == 0) begin
                busy  <= 1'b0;
                grant <= '0;
                state <= S_READY;
`ifdef AFE_SYNC_AUTO_RESYNC_EN
                tmr   <= TMR_W'(RESYNC_PERIOD - 1);
`endif
              end else begin
                gcnt  <= HO_W'(HOLDOFF);
                state <= S_GAP;
              end
            end else begin
              pcnt <= pcnt - 1'b1;
            end
          end
          S_GAP: begin
            if (gcnt <= HO_W'(1)) begin
              busy  <= 1'b0;
              grant <= '0;
              state <= S_READY;
`ifdef AFE_SYNC_AUTO_RESYNC_EN
              tmr   <= TMR_W'(RESYNC_PERIOD - 1);
`endif
            end else begin
              gcnt <= gcnt - 1'b1;
            end
          end
          S_READY: begin
            if (pick_vld) begin
              grant <= NUM_REQ'(1) << pick_idx;
              ptr   <= next_ptr;
              cnt   <= delay;
              busy  <= 1'b1;
              state <= S_WAIT;
            end
`ifdef AFE_SYNC_AUTO_RESYNC_EN
            else if (tmr == '0) begin
              // Automatic resync: ownerless, so grant and done stay 0.
              cnt   <= delay;
              busy  <= 1'b1;
              state <= S_WAIT;
            end else begin
              tmr <= tmr - 1'b1;
            end
`endif
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
